pll_lock_sequencer: RTL and testbench

Sequences the iCE40 PLL wrapper from the other side of its control interface. Drives the PLL's active-low reset and bypass inputs, consumes the asynchronous LOCK output, and produces a qualified system reset and ready flag for the VGA pixel-clock domain. Runs on the 50 MHz reference clock, because the PLL output is not trustworthy until lock is qualified. Retries on lock timeout; after repeated failure it falls back to PLL bypass and flags a fault.

---
 rtl/pll_lock_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Power-up and lock-qualification sequencer for the iCE40 PLL, clocked by the reference clock.
// Optional macro PLL_SEQ_LOSS_COUNTER_EN adds an 8-bit saturating RUN lock-loss counter.
module pll_lock_sequencer #(
   parameter int RESET_HOLD_CYCLES   = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 5000,
   parameter int LOCK_STABLE_CYCLES  = 256,
   parameter int MAX_RETRIES         = 3,
   parameter int BYPASS_ON_FAIL      = 1
) (
   input  logic                               REFERENCECLK,
   input  logic                               RESET,
   input  logic                               PLL_LOCK,
   output logic                               PLL_RESETB,
   output logic                               PLL_BYPASS,
   output logic                               SYS_RESET,
   output logic                               READY,
   output logic                               FAULT,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   RETRY_COUNT,
`ifdef PLL_SEQ_LOSS_COUNTER_EN
   output logic [2:0]                         STATE,
   output logic [7:0]                         LOSS_COUNT
`else
   output logic [2:0]                         STATE
`endif
);

   localparam int CNT_MAX_A = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_HOLD_CYCLES
                                                                        : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RW        = $clog2(MAX_RETRIES + 1);

   localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FALLBACK  = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic            lock_meta_q, lock_meta_d;
   logic            lock_s_q, lock_s_d;
   logic            pll_resetb_q, pll_resetb_d;
   logic            pll_bypass_q, pll_bypass_d;
   logic            sys_reset_q, sys_reset_d;
   logic            ready_q, ready_d;
   logic            fault_q, fault_d;

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      lock_meta_d = PLL_LOCK;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
      retry_d     = retry_q;

      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_LAST) begin
                  state_d = ST_FALLBACK;
               end else begin
                  retry_d = retry_q + RW'(1);
                  state_d = ST_HOLD;
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s_q)                 state_d = ST_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!lock_s_q) state_d = ST_HOLD;
         end
         ST_FALLBACK: begin
            cnt_d = '0;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase

      if (state_d != state_q) cnt_d = '0;
      if (state_d == ST_RUN)  retry_d = '0;

      // Outputs decode the next state so they move on the same edge as STATE.
      pll_resetb_d = !((state_d == ST_HOLD) || (state_d == ST_FALLBACK));
      pll_bypass_d = (state_d == ST_FALLBACK);
      ready_d      = (state_d == ST_RUN);
      fault_d      = fault_q || (state_d == ST_FALLBACK);
      if (state_d == ST_RUN)           sys_reset_d = 1'b0;
      else if (state_d == ST_FALLBACK) sys_reset_d = (BYPASS_ON_FAIL == 0);
      else                             sys_reset_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge REFERENCECLK) begin
      if (RESET) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         retry_q      <= '0;
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         pll_resetb_q <= 1'b0;
         pll_bypass_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         lock_meta_q  <= lock_meta_d;
         lock_s_q     <= lock_s_d;
         pll_resetb_q <= pll_resetb_d;
         pll_bypass_q <= pll_bypass_d;
         sys_reset_q  <= sys_reset_d;
         ready_q      <= ready_d;
         fault_q      <= fault_d;
      end
   end

   assign PLL_RESETB  = pll_resetb_q;
   assign PLL_BYPASS  = pll_bypass_q;
   assign SYS_RESET   = sys_reset_q;
   assign READY       = ready_q;
   assign FAULT       = fault_q;
   assign RETRY_COUNT = retry_q;
   assign STATE       = state_q;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
   logic [7:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if ((state_q == ST_RUN) && (state_d == ST_HOLD) && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
   end

   always_ff @(posedge REFERENCECLK) begin
      if (RESET) loss_q <= 8'd0;
      else       loss_q <= loss_d;
   end

   assign LOSS_COUNT = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer; edge k is the k-th clock edge after the last reset edge (edge 0).
// Inputs changed "after edge k" are first sampled at edge k+1; outputs are sampled 1 ns after an edge.
module tb_pll_lock_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       pll_resetb, pll_bypass, sys_reset, ready, fault;
   logic [1:0] retry_count;
   logic [2:0] state;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
   logic [7:0] loss_count;
`endif

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .RESET_HOLD_CYCLES  (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .BYPASS_ON_FAIL     (1)
   ) dut (
      .REFERENCECLK(clk),
      .RESET       (rst),
      .PLL_LOCK    (pll_lock),
      .PLL_RESETB  (pll_resetb),
      .PLL_BYPASS  (pll_bypass),
      .SYS_RESET   (sys_reset),
      .READY       (ready),
      .FAULT       (fault),
      .RETRY_COUNT (retry_count),
`ifdef PLL_SEQ_LOSS_COUNTER_EN
      .STATE       (state),
      .LOSS_COUNT  (loss_count)
`else
      .STATE       (state)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic go_to(input int e);
      while (cur < e) begin
         @(posedge clk);
         #1;
         cur++;
      end
   endtask

   // Holds reset for two edges; the second one becomes edge 0.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cur = 0;
      rst = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] want, input int limit);
      int n = 0;
      while (state !== want && n < limit) begin
         @(posedge clk); #1;
         cur++;
         n++;
      end
      check(tag, state, want);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state and normal lock, then lock loss in RUN.
      do_reset();
      check("rst_state",  state,       3'd0);
      check("rst_resetb", pll_resetb,  1'b0);
      check("rst_bypass", pll_bypass,  1'b0);
      check("rst_sysrst", sys_reset,   1'b1);
      check("rst_ready",  ready,       1'b0);
      check("rst_fault",  fault,       1'b0);
      check("rst_retry",  retry_count, 2'd0);
      go_to(3);
      check("n_resetb_e3", pll_resetb, 1'b0);
      go_to(4);
      check("n_resetb_e4", pll_resetb, 1'b1);
      check("n_state_e4",  state,      3'd1);
      go_to(9);
      pll_lock = 1'b1;
      go_to(11);
      check("n_state_e11", state, 3'd1);
      go_to(12);
      check("n_state_e12", state, 3'd2);
      go_to(19);
      check("n_ready_e19",  ready,     1'b0);
      check("n_sysrst_e19", sys_reset, 1'b1);
      go_to(20);
      check("n_ready_e20",  ready,      1'b1);
      check("n_sysrst_e20", sys_reset,  1'b0);
      check("n_state_e20",  state,      3'd3);
      check("n_bypass_e20", pll_bypass, 1'b0);
      check("n_fault_e20",  fault,      1'b0);
      go_to(30);
      pll_lock = 1'b0;
      go_to(32);
      check("loss_ready_e32", ready, 1'b1);
      go_to(33);
      check("loss_sysrst_e33", sys_reset,  1'b1);
      check("loss_ready_e33",  ready,      1'b0);
      check("loss_state_e33",  state,      3'd0);
      check("loss_resetb_e33", pll_resetb, 1'b0);
      go_to(36);
      check("loss_resetb_e36", pll_resetb, 1'b0);
      go_to(37);
      check("loss_resetb_e37", pll_resetb, 1'b1);
      pll_lock = 1'b1;
      go_to(40);
      check("relock_state_e40", state, 3'd2);
      go_to(47);
      check("relock_ready_e47", ready, 1'b0);
      go_to(48);
      check("relock_ready_e48", ready,       1'b1);
      check("relock_retry_e48", retry_count, 2'd0);

      // One-cycle lock glitch while in STABLE.
      pll_lock = 1'b0;
      do_reset();
      go_to(9);
      pll_lock = 1'b1;
      go_to(12);
      check("g_state_e12", state, 3'd2);
      go_to(16);
      pll_lock = 1'b0;
      go_to(17);
      pll_lock = 1'b1;
      go_to(18);
      check("g_state_e18", state, 3'd2);
      go_to(19);
      check("g_state_e19", state, 3'd1);
      go_to(20);
      check("g_state_e20", state, 3'd2);
      go_to(27);
      check("g_ready_e27", ready, 1'b0);
      go_to(28);
      check("g_ready_e28", ready,       1'b1);
      check("g_state_e28", state,       3'd3);
      check("g_retry_e28", retry_count, 2'd0);

      // Never locks: retry, then reset while waiting with one retry counted.
      pll_lock = 1'b0;
      do_reset();
      go_to(23);
      check("nl_state_e23", state,       3'd1);
      check("nl_retry_e23", retry_count, 2'd0);
      go_to(24);
      check("nl_state_e24", state,       3'd0);
      check("nl_retry_e24", retry_count, 2'd1);
      go_to(28);
      check("nl_state_e28", state, 3'd1);
      go_to(30);
      rst = 1'b1;
      go_to(31);
      check("mr_state",  state,       3'd0);
      check("mr_retry",  retry_count, 2'd0);
      check("mr_resetb", pll_resetb,  1'b0);
      check("mr_sysrst", sys_reset,   1'b1);
      check("mr_fault",  fault,       1'b0);
      rst = 1'b0;
      cur = 0;

      // Never locks through to FALLBACK, which ignores later lock.
      go_to(47);
      check("fb_state_e47", state, 3'd1);
      check("fb_fault_e47", fault, 1'b0);
      go_to(48);
      check("fb_state_e48",  state,       3'd4);
      check("fb_bypass_e48", pll_bypass,  1'b1);
      check("fb_fault_e48",  fault,       1'b1);
      check("fb_sysrst_e48", sys_reset,   1'b0);
      check("fb_ready_e48",  ready,       1'b0);
      check("fb_resetb_e48", pll_resetb,  1'b0);
      check("fb_retry_e48",  retry_count, 2'd1);
      pll_lock = 1'b1;
      go_to(70);
      check("fb_state_e70", state, 3'd4);
      check("fb_ready_e70", ready, 1'b0);
      check("fb_fault_e70", fault, 1'b1);
      rst = 1'b1;
      go_to(71);
      check("fbr_state",  state,      3'd0);
      check("fbr_fault",  fault,      1'b0);
      check("fbr_bypass", pll_bypass, 1'b0);
      check("fbr_sysrst", sys_reset,  1'b1);
      rst = 1'b0;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
      pll_lock = 1'b0;
      do_reset();
      check("lc_rst", loss_count, 8'd0);
      for (int i = 0; i < 300; i++) begin
         pll_lock = 1'b1;
         wait_state("lc_run", 3'd3, 60);
         pll_lock = 1'b0;
         wait_state("lc_hold", 3'd0, 10);
         if (i == 2) check("lc_three", loss_count, 8'd3);
      end
      check("lc_sat", loss_count, 8'd255);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
